// File: rtl/dcfir_coe_master.sv
// D-CFIR coefficient link master: shadow table of per-slave 3-tap complex
// coefficients, serialised onto the shared sdi bus, then committed with coe_load.
//
// state | meaning
// IDLE  | waiting for start; host may write the table
// SEND  | ssb low, driving one tap of the current slave per cycle
// GAP   | ssb high between slave frames, GAP_CYCLES long
// LOAD  | single-cycle coe_load / done pulse, then back to IDLE
module dcfir_coe_master #(
  parameter int NUM_SLAVES = 4,
  parameter int COE_W      = 10,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [COE_W-1:0]     wr_real,
  input  logic [COE_W-1:0]     wr_imag,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_drop,
  output logic                 ssb,
  output logic [3+2*COE_W-1:0] sdi,
  output logic                 coe_load
);

  localparam int TBL_N = 3 * NUM_SLAVES;
  localparam int ENT_W = 2 * COE_W;

  typedef enum logic [1:0] {IDLE, SEND, GAP, LOAD} state_t;

  state_t            state, state_nxt;
  logic [2:0]        slave, slave_nxt;
  logic [1:0]        tap, tap_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic [ENT_W-1:0]  tbl [TBL_N];
  logic              wr_ok, wr_bad, start_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic [ENT_W-1:0]  rd_data;

  assign wr_ok    = wr_en && !busy && (wr_addr < ADDR_W'(TBL_N));
  assign wr_bad   = wr_en && !wr_ok;
  assign start_ok = start && !abort && (state == IDLE);

  always_comb begin
    state_nxt   = state;
    slave_nxt   = slave;
    tap_nxt     = tap;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = SEND;
          slave_nxt = '0;
          tap_nxt   = '0;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tap != 2'd2) begin
          tap_nxt = tap + 2'd1;
        end else if (slave == 3'(NUM_SLAVES - 1)) begin
          state_nxt = LOAD;
        end else if (GAP_CYCLES == 0) begin
          slave_nxt = slave + 3'd1;
          tap_nxt   = '0;
        end else begin
          state_nxt   = GAP;
          gap_cnt_nxt = 4'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt == 4'd0) begin
          state_nxt = SEND;
          slave_nxt = slave + 3'd1;
          tap_nxt   = '0;
        end else begin
          gap_cnt_nxt = gap_cnt - 4'd1;
        end
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table read is for the cycle being launched; a write landing on the same
  // edge as start is forwarded so the broadcast carries the new value.
  always_comb begin
    rd_addr = ADDR_W'(slave_nxt) * ADDR_W'(3) + ADDR_W'(tap_nxt);
    rd_data = '0;
    for (int i = 0; i < TBL_N; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = tbl[i];
    end
    if (wr_ok && (wr_addr == rd_addr)) rd_data = {wr_real, wr_imag};
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state    <= IDLE;
      slave    <= '0;
      tap      <= '0;
      gap_cnt  <= '0;
      ssb      <= 1'b1;
      sdi      <= '0;
      coe_load <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      wr_drop  <= 1'b0;
      for (int i = 0; i < TBL_N; i++) tbl[i] <= '0;
    end else begin
      state    <= state_nxt;
      slave    <= slave_nxt;
      tap      <= tap_nxt;
      gap_cnt  <= gap_cnt_nxt;
      ssb      <= (state_nxt != SEND);
      sdi      <= (state_nxt == SEND) ? {slave_nxt, rd_data} : '0;
      coe_load <= (state_nxt == LOAD);
      done     <= (state_nxt == LOAD);
      busy     <= (state_nxt != IDLE);
      if (wr_bad)        wr_drop <= 1'b1;
      else if (start_ok) wr_drop <= 1'b0;
      for (int i = 0; i < TBL_N; i++) begin
        if (wr_ok && (wr_addr == ADDR_W'(i))) tbl[i] <= {wr_real, wr_imag};
      end
    end
  end

endmodule

// File: tb/tb_dcfir_coe_master.sv
// Self-checking bench for dcfir_coe_master: per-cycle expected pin values are
// queued when a broadcast is started and compared as the DUT drives the bus.
module tb_dcfir_coe_master;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst;
  logic        wr_en, start, abort;
  logic [3:0]  wr_addr;
  logic [9:0]  wr_real, wr_imag;
  logic        busy, done, wr_drop, ssb, coe_load;
  logic [22:0] sdi;

  logic        wr_en_1, start_1, abort_1;
  logic [3:0]  wr_addr_1;
  logic [9:0]  wr_real_1, wr_imag_1;
  logic        busy_1, done_1, wr_drop_1, ssb_1, coe_load_1;
  logic [22:0] sdi_1;

  dcfir_coe_master #(.NUM_SLAVES(4), .COE_W(10), .ADDR_W(4), .GAP_CYCLES(1)) dut (
    .CLK(CLK), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_real(wr_real),
    .wr_imag(wr_imag), .start(start), .abort(abort), .busy(busy), .done(done),
    .wr_drop(wr_drop), .ssb(ssb), .sdi(sdi), .coe_load(coe_load)
  );

  dcfir_coe_master #(.NUM_SLAVES(1), .COE_W(10), .ADDR_W(4), .GAP_CYCLES(0)) dut1 (
    .CLK(CLK), .rst(rst), .wr_en(wr_en_1), .wr_addr(wr_addr_1), .wr_real(wr_real_1),
    .wr_imag(wr_imag_1), .start(start_1), .abort(abort_1), .busy(busy_1), .done(done_1),
    .wr_drop(wr_drop_1), .ssb(ssb_1), .sdi(sdi_1), .coe_load(coe_load_1)
  );

  // {ssb, sdi, coe_load, done, busy}
  typedef logic [26:0] exp_t;
  localparam exp_t IDLE_V = {1'b1, 23'd0, 3'b000};
  localparam exp_t GAP_V  = {1'b1, 23'd0, 3'b001};
  localparam exp_t LOAD_V = {1'b1, 23'd0, 3'b111};

  exp_t       sb[$];
  exp_t       obs0, obs1, e;
  logic [19:0] mdl0 [12];
  logic [19:0] mdl1 [3];
  int tests = 0;
  int fails = 0;

  assign obs0 = {ssb, sdi, coe_load, done, busy};
  assign obs1 = {ssb_1, sdi_1, coe_load_1, done_1, busy_1};

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_bcast(input int n, input int g, input bit sel);
    logic [19:0] d;
    for (int s = 0; s < n; s++) begin
      for (int t = 0; t < 3; t++) begin
        if (sel) d = mdl1[s*3+t];
        else     d = mdl0[s*3+t];
        sb.push_back({1'b0, 3'(s), d, 3'b001});
      end
      if (s < n - 1)
        for (int k = 0; k < g; k++) sb.push_back(GAP_V);
    end
    sb.push_back(LOAD_V);
    sb.push_back(IDLE_V);
  endtask

  task automatic wr0(input int a, input logic [9:0] re, input logic [9:0] im);
    wr_en = 1'b1; wr_addr = 4'(a); wr_real = re; wr_imag = im;
    step;
    wr_en = 1'b0;
    if (a < 12) mdl0[a] = {re, im};
  endtask

  task automatic test_reset;
    int cyc;
    rst = 1'b0;
    step; step;
    tests++;
    if (obs0 !== IDLE_V || wr_drop !== 1'b0) begin
      fails++; $display("FAIL reset_pins got %h/%b exp %h/0", obs0, wr_drop, IDLE_V);
    end
    tests++;
    if (obs1 !== IDLE_V || wr_drop_1 !== 1'b0) begin
      fails++; $display("FAIL reset_pins_1 got %h/%b exp %h/0", obs1, wr_drop_1, IDLE_V);
    end
    rst = 1'b1;
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL reset_readback cyc %0d got %h exp %h", cyc, obs0, e);
      end
      cyc++;
      step;
    end
  endtask

  task automatic test_broadcast;
    int cyc;
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < 3; t++)
        wr0(s*3+t, 10'(10*s+t), 10'(-(10*s+t)));
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL bcast cyc %0d got %h exp %h", cyc, obs0, e);
      end
      cyc++;
      step;
    end
  endtask

  task automatic test_wr_busy;
    int cyc;
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL wr_busy cyc %0d got %h exp %h", cyc, obs0, e);
      end
      wr_en = (cyc == 3); wr_addr = 4'd2; wr_real = 10'h3FF; wr_imag = 10'h000;
      cyc++;
      step;
    end
    wr_en = 1'b0;
    tests++;
    if (wr_drop !== 1'b1) begin
      fails++; $display("FAIL wr_drop_set got %b exp 1", wr_drop);
    end
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    tests++;
    if (wr_drop !== 1'b0) begin
      fails++; $display("FAIL wr_drop_clear got %b exp 0", wr_drop);
    end
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL wr_busy_resend cyc %0d got %h exp %h", cyc, obs0, e);
      end
      cyc++;
      step;
    end
  endtask

  task automatic test_abort;
    int  cyc;
    bit  saw_load;
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL abort_pre cyc %0d got %h exp %h", cyc, obs0, e);
      end
      if (cyc < 10) step;
    end
    abort = 1'b1;
    step;
    abort = 1'b0;
    sb.delete();
    tests++;
    if (obs0 !== IDLE_V) begin
      fails++; $display("FAIL abort_idle got %h exp %h", obs0, IDLE_V);
    end
    saw_load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step;
      if (coe_load !== 1'b0 || done !== 1'b0 || ssb !== 1'b1) saw_load = 1'b1;
    end
    tests++;
    if (saw_load) begin
      fails++; $display("FAIL abort_no_load got activity exp none");
    end
    start = 1'b1; abort = 1'b1;
    step;
    start = 1'b0; abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || ssb !== 1'b1) begin
      fails++; $display("FAIL abort_wins busy %b ssb %b exp 0 1", busy, ssb);
    end
    step;
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL abort_restart cyc %0d got %h exp %h", cyc, obs0, e);
      end
      cyc++;
      step;
    end
  endtask

  task automatic test_bad_addr;
    int cyc;
    wr0(12, 10'h3FF, 10'h3FF);
    tests++;
    if (wr_drop !== 1'b1) begin
      fails++; $display("FAIL bad_addr_drop got %b exp 1", wr_drop);
    end
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL bad_addr_bcast cyc %0d got %h exp %h", cyc, obs0, e);
      end
      start = (cyc == 5);
      cyc++;
      step;
    end
    start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL start_busy_ignored busy %b exp 0", busy);
    end
  endtask

  task automatic test_gap0;
    int cyc;
    for (int t = 0; t < 3; t++) begin
      wr_en_1 = 1'b1; wr_addr_1 = 4'(t);
      wr_real_1 = 10'(10'h100 + t); wr_imag_1 = 10'(10'h200 + t);
      step;
      mdl1[t] = {wr_real_1, wr_imag_1};
    end
    wr_en_1 = 1'b1; wr_addr_1 = 4'd1; wr_real_1 = 10'h155; wr_imag_1 = 10'h2AA;
    start_1 = 1'b1;
    mdl1[1] = {10'h155, 10'h2AA};
    push_bcast(1, 0, 1'b1);
    step;
    wr_en_1 = 1'b0; start_1 = 1'b0;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs1 !== e) begin
        fails++; $display("FAIL gap0 cyc %0d got %h exp %h", cyc, obs1, e);
      end
      cyc++;
      step;
    end
  endtask

  task automatic test_mid_reset;
    int cyc;
    bit saw_load;
    start = 1'b1;
    step;
    start = 1'b0;
    wr0(0, 10'h001, 10'h001);
    step; step; step;
    rst = 1'b0;
    step;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) mdl0[i] = '0;
    tests++;
    if (obs0 !== IDLE_V || wr_drop !== 1'b0) begin
      fails++; $display("FAIL mid_reset got %h/%b exp %h/0", obs0, wr_drop, IDLE_V);
    end
    saw_load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step;
      if (coe_load !== 1'b0 || busy !== 1'b0) saw_load = 1'b1;
    end
    tests++;
    if (saw_load) begin
      fails++; $display("FAIL mid_reset_no_load got activity exp none");
    end
    start = 1'b1;
    push_bcast(4, 1, 1'b0);
    step;
    start = 1'b0;
    cyc = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (obs0 !== e) begin
        fails++; $display("FAIL mid_reset_cleared cyc %0d got %h exp %h", cyc, obs0, e);
      end
      cyc++;
      step;
    end
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_real = '0; wr_imag = '0; start = 1'b0; abort = 1'b0;
    wr_en_1 = 1'b0; wr_addr_1 = '0; wr_real_1 = '0; wr_imag_1 = '0;
    start_1 = 1'b0; abort_1 = 1'b0;
    for (int i = 0; i < 12; i++) mdl0[i] = '0;
    for (int i = 0; i < 3; i++)  mdl1[i] = '0;
    test_reset;
    test_broadcast;
    test_wr_busy;
    test_abort;
    test_bad_addr;
    test_gap0;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
